vector_loader: RTL

Parametrised DDR3 vector fetch engine for the inference datapath. On `start` it computes the address of vector `vec_index` (embedding row or weight row), issues `VEC_LEN` single-word read requests to the RAM reader with a bounded number in flight, and captures the in-order responses into an internal element buffer. In LOAD mode each fetched word replaces the buffer entry; in ACCUM mode it is saturating-added to the entry. The buffer is readable by the MAC sequencer and the hex debug display.

---
 rtl/vector_loader_pkg.sv | 29 ++
 rtl/vector_buffer.sv | 38 +++
 rtl/vector_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vector_loader_pkg.sv
// Shared types, mode encodings and the saturating adder for the vector fetch engine.
package vector_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } vl_state_t;

   localparam logic VL_MODE_LOAD  = 1'b0;
   localparam logic VL_MODE_ACCUM = 1'b1;

   // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned        w);
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sum = a + b;
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (w - 1));
      if (sum > hi) return hi;
      else if (sum < lo) return lo;
      else return sum;
   endfunction

endpackage

// File: rtl/vector_buffer.sv
// Element register array with load/accumulate write port, sync clear and combinational read.
module vector_buffer
   import vector_loader_pkg::*;
#(
   parameter int unsigned ELEM_W  = 16,
   parameter int unsigned VEC_LEN = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear_i,
   input  logic                       wr_en_i,
   input  logic                       wr_accum_i,
   input  logic [$clog2(VEC_LEN)-1:0] wr_idx_i,
   input  logic [ELEM_W-1:0]          wr_data_i,
   input  logic [$clog2(VEC_LEN)-1:0] rd_idx_i,
   output logic [ELEM_W-1:0]          rd_data_o
);

   logic [ELEM_W-1:0]  mem_q [VEC_LEN];
   logic signed [63:0] acc_wide;
   logic [ELEM_W-1:0]  wr_val;

   assign acc_wide  = sat_add(64'(signed'(mem_q[wr_idx_i])), 64'(signed'(wr_data_i)), ELEM_W);
   assign wr_val    = wr_accum_i ? ELEM_W'(acc_wide) : wr_data_i;
   assign rd_data_o = mem_q[rd_idx_i];

   // Clear wins over a write in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(VEC_LEN); i++) mem_q[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < int'(VEC_LEN); i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_val;
      end
   end

endmodule

// File: rtl/vector_loader.sv
// Vector fetch engine: issues VEC_LEN reads with bounded outstanding count and fills vector_buffer.
module vector_loader
   import vector_loader_pkg::*;
#(
   parameter int unsigned ELEM_W   = 16,
   parameter int unsigned VEC_LEN  = 16,
   parameter int unsigned NUM_VECS = 76,
   parameter int unsigned ADDR_W   = 27,
   parameter int unsigned MAX_OUT  = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        mode,
   input  logic [$clog2(NUM_VECS)-1:0] vec_index,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic                        clear,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic                        rd_req_valid,
   input  logic                        rd_req_ready,
   output logic [ADDR_W-1:0]           rd_req_addr,
   input  logic                        rd_rsp_valid,
   input  logic [ELEM_W-1:0]           rd_rsp_data,
   input  logic [$clog2(VEC_LEN)-1:0]  rd_idx,
   output logic [ELEM_W-1:0]           rd_data
);

   localparam int unsigned IDX_W = $clog2(VEC_LEN);
   localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

   vl_state_t         state_q, state_d;
   logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mode_q, mode_d;
   logic              busy_q, done_q, error_q, error_d;
   logic              req_fire, rsp_fire, fetching;

   assign fetching     = (state_q == ISSUE) || (state_q == DRAIN);
   assign rd_req_valid = (state_q == ISSUE) && (out_q < OUT_W'(MAX_OUT));
   assign req_fire     = rd_req_valid && rd_req_ready;
   assign rsp_fire     = rd_rsp_valid && fetching;
   assign rd_req_addr  = addr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
         out_q     <= '0;
         addr_q    <= '0;
         mode_q    <= VL_MODE_LOAD;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
         out_q     <= out_d;
         addr_q    <= addr_d;
         mode_q    <= mode_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == FINISH);
         error_q   <= error_d;
      end
   end

   // addr_q holds the row base plus the number of requests already transferred.
   always_comb begin
      state_d   = state_q;
      req_cnt_d = req_cnt_q;
      rsp_cnt_d = rsp_cnt_q;
      out_d     = out_q;
      addr_d    = addr_q;
      mode_d    = mode_q;
      error_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (32'(vec_index) >= NUM_VECS) begin
                  error_d = 1'b1;
               end else begin
                  mode_d    = mode;
                  req_cnt_d = '0;
                  rsp_cnt_d = '0;
                  out_d     = '0;
                  addr_d    = base_addr + ADDR_W'(vec_index) * ADDR_W'(VEC_LEN);
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (req_fire) begin
               req_cnt_d = req_cnt_q + CNT_W'(1);
               addr_d    = addr_q + ADDR_W'(1);
               if (req_cnt_q == CNT_W'(VEC_LEN - 1)) state_d = DRAIN;
            end
         end
         DRAIN:   state_d = state_q;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (rsp_fire) begin
         rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
         if (rsp_cnt_q == CNT_W'(VEC_LEN - 1)) state_d = FINISH;
      end

      unique case ({req_fire, rsp_fire})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_d;
      endcase
   end

   vector_buffer #(
      .ELEM_W  (ELEM_W),
      .VEC_LEN (VEC_LEN)
   ) u_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear_i    (clear && (state_q == IDLE)),
      .wr_en_i    (rsp_fire),
      .wr_accum_i (mode_q == VL_MODE_ACCUM),
      .wr_idx_i   (rsp_cnt_q[IDX_W-1:0]),
      .wr_data_i  (rd_rsp_data),
      .rd_idx_i   (rd_idx),
      .rd_data_o  (rd_data)
   );

endmodule
